// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, its two requesters and the 256x8 memory.
// slave = arbiter view, master = requester/memory view.
interface mem_arbiter_if #(
  parameter int word_size = 8
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [word_size-1:0] cpu_addr;
  logic [word_size-1:0] cpu_wdata;
  logic                 cpu_gnt;

  logic                 host_req;
  logic                 host_we;
  logic [word_size-1:0] host_addr;
  logic [word_size-1:0] host_wdata;
  logic                 host_lock;
  logic                 host_gnt;

  logic [word_size-1:0] mem_addr;
  logic [word_size-1:0] mem_wdata;
  logic                 mem_we;
  logic [word_size-1:0] mem_rdata;

  logic [word_size-1:0] rdata;
  logic                 rvalid;
  logic                 rsrc;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output cpu_gnt, host_gnt,
    output mem_addr, mem_wdata, mem_we,
    output rdata, rvalid, rsrc
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  cpu_gnt, host_gnt,
    input  mem_addr, mem_wdata, mem_we,
    input  rdata, rvalid, rsrc
  );
endinterface

// File: rtl/mem_arbiter.sv
// Core/host arbiter for the shared single-port program/data memory, with bounded host lock.
// Define ARB_FIXED_PRIO_EN for host-wins tie-breaks; default build is round-robin.
module mem_arbiter #(
  parameter int word_size = 8,
  parameter int MAX_LOCK  = 16
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int LW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_HOST} state_t;
  typedef enum logic {OWN_CPU, OWN_HOST} owner_t;

  state_t               state_q, state_d;
  owner_t               last_owner;
  logic [LW-1:0]        lock_cnt;
  logic [word_size-1:0] addr_hold, wdata_hold;
  logic                 force_cpu;
  logic                 grant_read;

  always_comb begin
    state_d        = S_IDLE;
    bus.cpu_gnt    = 1'b0;
    bus.host_gnt   = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = addr_hold;
    bus.mem_wdata  = wdata_hold;
    grant_read     = 1'b0;
    force_cpu      = (state_q == S_HOST) && bus.cpu_req && (lock_cnt == LOCK_LAST);

    if ((state_q == S_HOST) && bus.host_lock && bus.host_req && !force_cpu) begin
      state_d = S_HOST;
    end else if (bus.cpu_req && bus.host_req) begin
`ifdef ARB_FIXED_PRIO_EN
      state_d = force_cpu ? S_CPU : S_HOST;
`else
      state_d = (last_owner == OWN_HOST) ? S_CPU : S_HOST;
`endif
    end else if (bus.cpu_req) begin
      state_d = S_CPU;
    end else if (bus.host_req) begin
      state_d = S_HOST;
    end

    case (state_q)
      S_CPU: begin
        bus.cpu_gnt   = 1'b1;
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        grant_read    = !bus.cpu_we;
      end
      S_HOST: begin
        bus.host_gnt  = 1'b1;
        bus.mem_we    = bus.host_we;
        bus.mem_addr  = bus.host_addr;
        bus.mem_wdata = bus.host_wdata;
        grant_read    = !bus.host_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_owner <= OWN_HOST;
      lock_cnt   <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.rsrc   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_CPU) begin
        last_owner <= OWN_CPU;
      end else if (state_d == S_HOST) begin
        last_owner <= OWN_HOST;
      end

      // Only host cycles with the core waiting advance the starvation counter.
      if (state_q != S_HOST) begin
        lock_cnt <= '0;
      end else if (bus.cpu_req && (lock_cnt != LOCK_LAST)) begin
        lock_cnt <= lock_cnt + 1'b1;
      end

      if (state_q != S_IDLE) begin
        addr_hold  <= bus.mem_addr;
        wdata_hold <= bus.mem_wdata;
      end

      bus.rvalid <= grant_read;
      if (grant_read) begin
        bus.rdata <= bus.mem_rdata;
        bus.rsrc  <= (state_q == S_HOST);
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the arbitration rules.
module tb_mem_arbiter;
  localparam int MAX_LOCK = 16;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_CPU  = 2'd1;
  localparam logic [1:0] O_HOST = 2'd2;

  typedef struct packed {
    logic       cr;
    logic       cw;
    logic       hr;
    logic       hw;
    logic       hl;
    logic [1:0] exp_rr;
    logic [1:0] exp_fp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.word_size(8)) bus ();

  mem_arbiter #(.word_size(8), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] tb_mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256];
  assign bus.mem_rdata = tb_mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [1:0] owner_now();
    return {bus.host_gnt, bus.cpu_gnt};
  endfunction

  // Continuous dual requests: round-robin alternates, fixed priority gives the
  // core one slot after every MAX_LOCK host slots.
  function automatic logic [1:0] alt_exp(input int unsigned k);
    if (FIXED) return ((k % (MAX_LOCK + 1)) == MAX_LOCK) ? O_CPU : O_HOST;
    return ((k % 2) == 0) ? O_CPU : O_HOST;
  endfunction

  // Locked burst with the core waiting: round-robin core wins the first tie, then
  // the pattern is MAX_LOCK host slots followed by one core slot.
  function automatic logic [1:0] burst_exp(input int unsigned k);
    int unsigned p;
    if (FIXED) begin
      p = k;
    end else begin
      if (k == 0) return O_CPU;
      p = k - 1;
    end
    return ((p % (MAX_LOCK + 1)) == MAX_LOCK) ? O_CPU : O_HOST;
  endfunction

  initial begin
    logic [1:0] prev_exp;
    logic [7:0] hold_a, hold_d, e_a, e_d, old_val;
    logic       e_we;
    int unsigned hcnt;

    // fields: cr cw hr hw hl exp_rr exp_fp (grant expected in the next cycle)
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_CPU,  O_HOST};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_HOST, O_HOST};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, O_IDLE};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_CPU,  O_CPU};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_HOST, O_HOST};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, O_HOST, O_HOST};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_CPU,  O_HOST};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_CPU,  O_CPU};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_HOST, O_HOST};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_CPU,  O_HOST};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_HOST, O_HOST};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE, O_IDLE};

    // Reset values, sampled while reset is still held
    rst = 1'b1;
    #1;
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnts",   {bus.cpu_gnt, bus.host_gnt, bus.mem_we}, 3'b000);
    chk("rst_addr",   bus.mem_addr, 8'h00);
    chk("rst_wdata",  bus.mem_wdata, 8'h00);
    chk("rst_rdata",  bus.rdata, 8'h00);
    chk("rst_rvalid", {bus.rvalid, bus.rsrc}, 2'b00);
    rst = 1'b1;

    // Single core write, then host read-back
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hA5;
    step();
    chk("wr_cpu_gnt", {bus.cpu_gnt, bus.host_gnt}, 2'b10);
    chk("wr_mem_we",  bus.mem_we, 1'b1);
    chk("wr_addr",    bus.mem_addr, 8'h10);
    chk("wr_wdata",   bus.mem_wdata, 8'hA5);
    bus.cpu_req = 1'b0;
    step();
    chk("wr_gnt_drop",  {bus.cpu_gnt, bus.mem_we}, 2'b00);
    chk("wr_addr_hold", bus.mem_addr, 8'h10);
    chk("wr_mem",       tb_mem[8'h10], 8'hA5);
    bus.cpu_we = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h10;
    step();
    chk("hrd_gnt", {bus.cpu_gnt, bus.host_gnt, bus.mem_we}, 3'b010);
    bus.host_req = 1'b0;
    step();
    chk("hrd_rvalid", {bus.rvalid, bus.rsrc}, 2'b11);
    chk("hrd_rdata",  bus.rdata, 8'hA5);
    step();
    chk("hrd_rvalid_drop", bus.rvalid, 1'b0);

    // Read pipeline: host preloads 0x33, core reads it back
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h33; bus.host_wdata = 8'h5C;
    step();
    bus.host_req = 1'b0;
    step();
    bus.host_we = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h33;
    step();
    chk("crd_gnt", {bus.cpu_gnt, bus.rvalid}, 2'b10);
    bus.cpu_req = 1'b0;
    step();
    chk("crd_rvalid", {bus.rvalid, bus.rsrc}, 2'b10);
    chk("crd_rdata",  bus.rdata, 8'h5C);
    step();
    chk("crd_rvalid_drop", bus.rvalid, 1'b0);
    chk("crd_rdata_hold",  bus.rdata, 8'h5C);

    // Reset during a host write that follows a core read (rvalid pending)
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h33;
    step();
    old_val = tb_mem[8'h20];
    bus.cpu_req = 1'b0;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h20; bus.host_wdata = 8'h77;
    step();
    chk("mid_pre_gnt", {bus.host_gnt, bus.mem_we, bus.rvalid}, 3'b111);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_gnts",   {bus.cpu_gnt, bus.host_gnt, bus.mem_we}, 3'b000);
    chk("mid_rvalid", {bus.rvalid, bus.rsrc}, 2'b00);
    chk("mid_addr",   {bus.mem_addr, bus.mem_wdata}, 16'h0000);
    chk("mid_rdata",  bus.rdata, 8'h00);
    @(posedge clk);
    #1;
    chk("mid_mem_unchanged", tb_mem[8'h20], old_val);
    rst = 1'b1;
    idle_inputs();

    // Vector table
    do_reset();
    prev_exp = O_IDLE;
    hold_a = 8'h00;
    hold_d = 8'h00;
    for (int unsigned k = 0; k <= 12; k++) begin
      vec_t v;
      v = (k < 12) ? tbl[k] : '0;
      bus.cpu_req = v.cr; bus.cpu_we = v.cw;
      bus.cpu_addr = 8'h40 + 8'(k); bus.cpu_wdata = 8'hC0 + 8'(k);
      bus.host_req = v.hr; bus.host_we = v.hw; bus.host_lock = v.hl;
      bus.host_addr = 8'h80 + 8'(k); bus.host_wdata = 8'hD0 + 8'(k);
      #1;
      e_we = (prev_exp == O_CPU) ? v.cw : (prev_exp == O_HOST) ? v.hw : 1'b0;
      e_a  = (prev_exp == O_CPU) ? bus.cpu_addr : (prev_exp == O_HOST) ? bus.host_addr : hold_a;
      e_d  = (prev_exp == O_CPU) ? bus.cpu_wdata : (prev_exp == O_HOST) ? bus.host_wdata : hold_d;
      chk("tbl_owner",  owner_now(), prev_exp);
      chk("tbl_mem_we", bus.mem_we, e_we);
      chk("tbl_addr",   bus.mem_addr, e_a);
      chk("tbl_wdata",  bus.mem_wdata, e_d);
      hold_a = e_a;
      hold_d = e_d;
      prev_exp = FIXED ? v.exp_fp : v.exp_rr;
      step();
    end

    // Continuous dual requests without lock
    do_reset();
    bus.cpu_req = 1'b1; bus.host_req = 1'b1;
    for (int unsigned k = 0; k < 34; k++) begin
      step();
      chk("alt_owner", owner_now(), alt_exp(k));
    end
    idle_inputs();

    // Host burst lock with the core waiting
    do_reset();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h33;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_lock = 1'b1;
    bus.host_addr = 8'hA0; bus.host_wdata = 8'h3C;
    hcnt = 0;
    for (int unsigned k = 0; (k < 80) && (hcnt < 40); k++) begin
      step();
      chk("burst_owner", owner_now(), burst_exp(k));
      if (owner_now() == O_HOST) hcnt++;
    end
    chk("burst_host_count", hcnt, 40);
    idle_inputs();

    // Randomized traffic against the behavioural model
    do_reset();
    ref_mem = tb_mem;
    begin
      logic [1:0]  m_own, m_nxt, m_last;
      int unsigned m_wait;
      logic        m_rv, m_rs;
      logic [7:0]  m_rd, m_ha, m_hd;
      logic        cr, hr, hl;
      m_own = O_IDLE; m_last = O_HOST; m_wait = 0;
      m_rv = 1'b0; m_rs = 1'b0; m_rd = 8'h00; m_ha = 8'h00; m_hd = 8'h00;
      for (int unsigned k = 0; k < 400; k++) begin
        cr = ($urandom_range(0, 9) < 6);
        hr = ($urandom_range(0, 9) < 9);
        hl = ($urandom_range(0, 9) < 8);
        bus.cpu_req = cr; bus.cpu_we = 1'($urandom_range(0, 1));
        bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
        bus.host_req = hr; bus.host_we = 1'($urandom_range(0, 1)); bus.host_lock = hl;
        bus.host_addr = 8'($urandom); bus.host_wdata = 8'($urandom);
        #1;
        e_we = (m_own == O_CPU) ? bus.cpu_we : (m_own == O_HOST) ? bus.host_we : 1'b0;
        e_a  = (m_own == O_CPU) ? bus.cpu_addr : (m_own == O_HOST) ? bus.host_addr : m_ha;
        e_d  = (m_own == O_CPU) ? bus.cpu_wdata : (m_own == O_HOST) ? bus.host_wdata : m_hd;
        chk("rnd_owner",  owner_now(), m_own);
        chk("rnd_mem_we", bus.mem_we, e_we);
        chk("rnd_addr",   bus.mem_addr, e_a);
        chk("rnd_wdata",  bus.mem_wdata, e_d);
        chk("rnd_rvalid", {bus.rvalid, bus.rsrc}, {m_rv, m_rs});
        chk("rnd_rdata",  bus.rdata, m_rd);

        // memory effect of this cycle's access
        m_rv = 1'b0;
        if (m_own != O_IDLE) begin
          if (e_we) begin
            ref_mem[e_a] = e_d;
          end else begin
            m_rv = 1'b1;
            m_rs = (m_own == O_HOST);
            m_rd = ref_mem[e_a];
          end
        end
        m_ha = e_a;
        m_hd = e_d;

        // who owns the next cycle
        if ((m_own == O_HOST) && hl && hr && !(cr && (m_wait >= MAX_LOCK - 1)))
          m_nxt = O_HOST;
        else if (cr && hr)
          m_nxt = FIXED ? (((m_own == O_HOST) && (m_wait >= MAX_LOCK - 1)) ? O_CPU : O_HOST)
                        : ((m_last == O_HOST) ? O_CPU : O_HOST);
        else if (cr)
          m_nxt = O_CPU;
        else if (hr)
          m_nxt = O_HOST;
        else
          m_nxt = O_IDLE;

        // host slots spent while the core was kept waiting
        if (m_own != O_HOST) m_wait = 0;
        else if (cr && (m_wait < MAX_LOCK - 1)) m_wait++;
        if (m_nxt != O_IDLE) m_last = m_nxt;
        m_own = m_nxt;
        step();
      end
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported 256x8 program/data memory between the processor core and the external host loader. It grants one access per cycle, muxes address/data/write-enable onto the memory port and returns registered read data to the owner. It supports host burst locking with a bounded hold so the core cannot starve during program download.

## Interface

Parameters:
- word_size, 8, data and address width
- MAX_LOCK, 16, maximum consecutive host grants while host_lock is held and cpu_req is pending

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_req  input  1  core requests one access; held until cpu_gnt
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  word_size  core access address
- cpu_wdata  input  word_size  core write data
- cpu_gnt  output  1  core owns the memory port this cycle
- host_req, host_we, host_addr, host_wdata  input  1/1/word_size/word_size  host equivalents
- host_lock  input  1  keep host ownership across consecutive accesses
- host_gnt  output  1  host owns the memory port this cycle
- mem_addr  output  word_size  to memory address
- mem_wdata  output  word_size  to memory data_in
- mem_we  output  1  to memory write strobe
- mem_rdata  input  word_size  combinational memory read data
- rdata  output  word_size  registered read data for the last read
- rvalid  output  1  one-cycle pulse, rdata valid; qualified by rsrc
- rsrc  output  1  0 = read belonged to core, 1 = host

## Operation

- State machine: S_IDLE, S_CPU, S_HOST. cpu_gnt = (state==S_CPU); host_gnt = (state==S_HOST).
- Arbitration at every rising edge, from current req inputs:
  - No req: S_IDLE.
  - One req: grant it.
  - Both req: grant the requester not served last (last_owner register, reset to host so core wins the first tie).
  - State S_HOST, host_lock=1, host_req=1: stay S_HOST. This holds unless cpu_req=1 and lock_cnt has reached MAX_LOCK-1, which forces S_CPU.
- lock_cnt: increments per consecutive host grant while cpu_req=1, clears on any core grant or on S_IDLE. It saturates at MAX_LOCK-1. Width is clog2(MAX_LOCK).
- Port mux in S_CPU drives cpu_addr, cpu_wdata and cpu_we. S_HOST drives the host signals. S_IDLE drives mem_we=0, with mem_addr and mem_wdata holding their last values.
- mem_we is never 1 outside a grant cycle.
- Reads: at the end of a grant cycle with we=0, capture rdata<=mem_rdata and set rvalid=1 and rsrc=owner for the following cycle. rdata holds until the next read.
- Requester protocol: keep req, we, addr and wdata stable until the gnt cycle. Deassert or change them in the cycle after gnt. req still high after gnt counts as a new request.

## Timing

- Reset values: state S_IDLE, cpu_gnt=0, host_gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, rvalid=0, rsrc=0, lock_cnt=0, last_owner=host.
- Latency from req high in cycle n to gnt in cycle n+1, with the write committed at the edge ending n+1. For a read, rvalid and rdata appear in cycle n+2.
- Throughput is one access per cycle. Continuous dual requests without lock alternate C,H,C,H.
- Reset asserted mid-grant: gnt and mem_we drop immediately (asynchronously), no write occurs at the next edge, and a pending rvalid is cancelled.
- Both req in same cycle after reset: core granted first.
- host_lock asserted with host_req=0: ignored.

## Configuration

- ARB_FIXED_PRIO_EN defined: on contention the host always wins. last_owner is ignored for tie-breaks, but the MAX_LOCK starvation bound still forces a core grant after MAX_LOCK consecutive host grants while cpu_req=1.
- Undefined (default): round-robin as described in Operation.

## Test plan

- Single core write: cpu_req=1, cpu_we=1, addr 0x10, wdata 0xA5. Required: cpu_gnt one cycle later, mem_we=1 for exactly one cycle. A host read of 0x10 afterwards returns rdata=0xA5 with rsrc=1.
- Tie after reset: both req in the same cycle. Required: core granted first, then host. Continued requests alternate C,H,C,H for 8 cycles.
- Host burst lock: host_lock=1, 40 writes, cpu_req held high. Required: at most 16 consecutive host grants, then exactly one core grant, then host resumes. lock_cnt cleared at the core grant.
- Read pipeline: core read of 0x33 containing 0x5C. Required: rvalid pulse 2 cycles after req, rdata=0x5C, rsrc=0, and rdata held after rvalid falls.
- Reset mid-write: rst low during a host grant cycle. Required: host_gnt and mem_we drop immediately, memory at the target address is unchanged, and all outputs are at reset values.
- With ARB_FIXED_PRIO_EN: continuous dual requests, no lock. Required: host wins each tie, and the core still receives one grant per 16 host grants.
